// File: rtl/ysyx_25060170_ifu.sv
// ysyx_25060170_ifu: instruction fetch unit.
// Owns the PC, fetches one instruction at a time over a valid/ready request
// channel with a variable-latency response, and holds it for decode.
// Optional build macro IFU_PERF_CNT_EN adds fetch/stall performance counters.
module ysyx_25060170_ifu #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        halt_i
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_STOP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_pc;   // restart target once the in-flight response is dropped
  logic        drop;      // exactly one outstanding response must be discarded
  logic [31:0] flush_tgt;
  logic [31:0] redir_tgt;

  assign flush_tgt     = flush_pc_i & ALIGN_MASK;
  assign redir_tgt     = redirect_pc_i & ALIGN_MASK;
  assign imem_req_addr = pc;

  // Fetch FSM; every output except the address is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_REQ;
      pc             <= RESET_PC;
      pend_pc        <= '0;
      drop           <= 1'b0;
      imem_req_valid <= 1'b0;
      inst_valid_o   <= 1'b0;
      inst_o         <= '0;
      pc_o           <= RESET_PC;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_valid) begin
            // Mid-handshake: address must stay put, so a flush is deferred
            // by marking the response of this request for dropping.
            if (flush_i) begin
              drop    <= 1'b1;
              pend_pc <= flush_tgt;
            end
            if (imem_req_ready) begin
              imem_req_valid <= 1'b0;
              state          <= S_WAIT;
            end
          end else if (flush_i) begin
            pc             <= flush_tgt;
            imem_req_valid <= 1'b1;
          end else if (halt_i) begin
            state <= S_STOP;
          end else begin
            imem_req_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop || flush_i) begin
              drop           <= 1'b0;
              pc             <= flush_i ? flush_tgt : pend_pc;
              imem_req_valid <= 1'b1;
              state          <= S_REQ;
            end else begin
              inst_o       <= imem_rsp_data;
              pc_o         <= pc;
              inst_valid_o <= 1'b1;
              state        <= S_HOLD;
            end
          end else if (flush_i) begin
            drop    <= 1'b1;
            pend_pc <= flush_tgt;
          end
        end
        S_HOLD: begin
          if (flush_i) begin
            inst_valid_o   <= 1'b0;
            pc             <= flush_tgt;
            imem_req_valid <= 1'b1;
            state          <= S_REQ;
          end else if (inst_ready_i) begin
            inst_valid_o <= 1'b0;
            pc           <= redirect_valid_i ? redir_tgt : pc + 32'd4;
            if (halt_i) begin
              state <= S_STOP;
            end else begin
              imem_req_valid <= 1'b1;
              state          <= S_REQ;
            end
          end
        end
        S_STOP: begin
          if (flush_i) begin
            pc             <= flush_tgt;
            imem_req_valid <= 1'b1;
            state          <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Performance counters: delivered instructions and fetch-side stall cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (inst_valid_o && inst_ready_i)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state == S_WAIT || (state == S_HOLD && !inst_ready_i))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
